trng_word_unpacker: RTL and testbench

Consumer-side counterpart of the 16-bit word packer in the TRNG chain. It accepts single-cycle valid pulses carrying packed 16-bit entropy words. It buffers them in a small circular queue and serialises each word into OUT_W-bit beats, LSB slice first, over a valid/ready handshake. It sits between the entropy packer and any downstream bit consumer (reseed logic, CSR readout); the source has no backpressure, so overflow is detected and flagged.

---
 rtl/trng_pkg.sv | 16 +
 rtl/trng_word_queue.sv | 49 ++++
 rtl/trng_word_unpacker.sv | 126 ++++++++++++
 tb/tb_trng_word_unpacker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG word unpacker: default word width,
// serialiser state encoding and the beats-per-word helper.
package trng_pkg;

  localparam int WORD_W_DEF = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } unp_state_e;

  function automatic int beats_per_word(input int word_w, input int out_w);
    return word_w / out_w;
  endfunction

endpackage

// File: rtl/trng_word_queue.sv
// Circular word buffer; the caller only pushes when not full (or full with a pop)
// and only pops when not empty.
module trng_word_queue #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trng_word_unpacker.sv
// Queues packed TRNG words and serialises them LSB-slice first over valid/ready.
// Optional repetition alarm is built when TRNG_REPCNT_EN is defined.
module trng_word_unpacker
  import trng_pkg::*;
#(
  parameter  int WORD_W    = WORD_W_DEF,
  parameter  int OUT_W     = 4,
  parameter  int DEPTH     = 4,
  parameter  int REP_LIMIT = 3,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic              rep_alarm
);

  localparam int BEATS  = beats_per_word(WORD_W, OUT_W);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  unp_state_e        state;
  logic [BEAT_W-1:0] beat;
  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] q_rdata;
  logic              q_full;
  logic              q_empty;
  logic              push;
  logic              pop;
  logic              hs;
  logic              last_beat;
  logic              rep_block;
  logic [OUT_W-1:0]  slices [BEATS];

  assign out_valid = (state == SERVE);
  assign hs        = out_valid && out_ready;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  // Pop from the registered level only: a word pushed this edge is never bypassed
  assign pop       = !q_empty && ((state == IDLE) || (hs && last_beat));
  assign push      = in_valid && !rep_block && (!q_full || pop);

  trng_word_queue #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_word),
    .rdata (q_rdata),
    .level (level),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat     <= '0;
      cur_word <= '0;
    end else if (pop) begin
      state    <= SERVE;
      beat     <= '0;
      cur_word <= q_rdata;
    end else if (hs) begin
      if (last_beat) begin
        state <= IDLE;
        beat  <= '0;
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < BEATS; i++) begin : g_slice
    assign slices[i] = cur_word[i*OUT_W +: OUT_W];
  end

  assign out_data = out_valid ? slices[beat] : '0;

  // Words discarded by the repetition alarm are not overflow drops
  always_ff @(posedge clk) begin
    if (reset)                              overflow <= 1'b0;
    else if (in_valid && !rep_block && !push) overflow <= 1'b1;
  end

`ifdef TRNG_REPCNT_EN
  localparam int CNT_W = $clog2(REP_LIMIT + 1);

  logic [WORD_W-1:0] prev_word;
  logic              have_prev;
  logic [CNT_W-1:0]  rep_cnt;
  logic [CNT_W-1:0]  rep_cnt_nxt;
  logic              alarm_q;

  assign rep_cnt_nxt = (have_prev && (in_word == prev_word)) ? rep_cnt + CNT_W'(1)
                                                             : CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_word <= '0;
      have_prev <= 1'b0;
      rep_cnt   <= '0;
      alarm_q   <= 1'b0;
    end else if (push) begin
      prev_word <= in_word;
      have_prev <= 1'b1;
      rep_cnt   <= rep_cnt_nxt;
      if (rep_cnt_nxt >= CNT_W'(REP_LIMIT)) alarm_q <= 1'b1;
    end
  end

  assign rep_block = alarm_q;
  assign rep_alarm = alarm_q;
`else
  assign rep_block = 1'b0;
  assign rep_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_trng_word_unpacker.sv
// Directed, table-driven bench for trng_word_unpacker (default parameters).
module tb_trng_word_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_word;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [2:0]  level;
  logic        overflow;
  logic        rep_alarm;

  int errors = 0;
  int checks = 0;

  trng_word_unpacker dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .rep_alarm (rep_alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // order holds the expected beats in emission order, first beat in the top nibble
  typedef struct {
    logic [15:0] word;
    logic [15:0] order;
  } vec_t;

  vec_t vecs [4];

  task automatic stall_seq(input logic [15:0] w, input logic [15:0] order);
    do_reset;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = w;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("stall_pre_b2", out_data, order[7:4]);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", out_data, order[7:4]);
      tick;
    end
    out_ready = 1'b1;
    chk("resume_b2", out_data, order[7:4]);
    tick;
    chk("resume_b3", out_data, order[3:0]);
    chk("resume_b3_valid", out_valid, 1);
    tick;
    chk("resume_done", out_valid, 0);
  endtask

  initial begin
    logic [15:0] words [6];
    logic [15:0] seq;
    logic [15:0] w;
    int          maxlvl;
    int          n;

    vecs[0] = '{16'hA5C3, 16'h3C5A};
    vecs[1] = '{16'h1234, 16'h4321};
    vecs[2] = '{16'hF00E, 16'hE00F};
    vecs[3] = '{16'h8421, 16'h1248};

    do_reset;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_level",     level, 0);
    chk("rst_overflow",  overflow, 0);
    chk("rst_rep_alarm", rep_alarm, 0);

    // single-word latency and slice order; out_ready held high while idle
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      in_valid = 1'b1;
      in_word  = vecs[v].word;
      tick;
      in_valid = 1'b0;
      chk("lat_not_yet", out_valid, 0);
      chk("lat_level", level, 1);
      tick;
      for (int b = 0; b < 4; b++) begin
        chk("vec_valid", out_valid, 1);
        chk("vec_beat", out_data, vecs[v].order[15-4*b -: 4]);
        tick;
      end
      chk("vec_done", out_valid, 0);
    end

    // back-to-back words, no bubble
    do_reset;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = 16'h1234;
    tick;
    maxlvl = int'(level);
    in_word = 16'h5678;
    tick;
    in_valid = 1'b0;
    seq = 16'h4321;
    for (int b = 0; b < 8; b++) begin
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (b == 4) seq = 16'h8765;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_beat", out_data, seq[15-4*(b%4) -: 4]);
      tick;
    end
    chk("b2b_done", out_valid, 0);
    chk("b2b_level_peak", maxlvl, 1);

    // overflow with stalled consumer
    do_reset;
    words[0] = 16'h1A2B; words[1] = 16'h3C4D; words[2] = 16'h5E6F;
    words[3] = 16'h7081; words[4] = 16'h92A3; words[5] = 16'hB4C5;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_word  = words[k];
      tick;
    end
    in_valid = 1'b0;
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_serving", out_valid, 1);
    chk("ovf_head_beat", out_data, 4'hB);
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 24) begin
      w = words[n/4];
      chk("drain_beat", out_data, w[(n%4)*4 +: 4]);
      n++;
      tick;
    end
    chk("drain_count", n, 20);
    chk("ovf_sticky", overflow, 1);

    // reset mid-word (overflow still set from above)
    in_valid = 1'b1;
    in_word  = 16'hABCD;
    tick;
    in_valid = 1'b0;
    tick;
    chk("mid_b0", out_data, 4'hD);
    tick;
    chk("mid_b1", out_data, 4'hC);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovf", overflow, 0);
    in_valid = 1'b1;
    in_word  = 16'h0001;
    tick;
    in_valid = 1'b0;
    tick;
    chk("post_b0", out_data, 4'h1);
    chk("post_b0_valid", out_valid, 1);
    for (int b = 1; b < 4; b++) begin
      tick;
      chk("post_beat", out_data, 4'h0);
      chk("post_valid", out_valid, 1);
    end
    tick;
    chk("post_done", out_valid, 0);

    // backpressure stall at beat 2
    stall_seq(16'hFFFF, 16'hFFFF);
    stall_seq(16'h4321, 16'h1234);

    // repetition test
    do_reset;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_word  = 16'hBEEF;
      tick;
    end
    in_valid = 1'b0;
    chk("rep_level3", level, 2);
`ifdef TRNG_REPCNT_EN
    chk("rep_alarm_set", rep_alarm, 1);
`else
    chk("rep_alarm_off", rep_alarm, 0);
`endif
    in_valid = 1'b1;
    in_word  = 16'h1234;
    tick;
    in_valid = 1'b0;
`ifdef TRNG_REPCNT_EN
    chk("rep_discard_level", level, 2);
    chk("rep_alarm_sticky", rep_alarm, 1);
`else
    chk("rep_off_level", level, 3);
    chk("rep_alarm_still_off", rep_alarm, 0);
`endif
    chk("rep_no_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
